// File: rtl/tx_frame_serializer.sv
// UART TX data serializer: one-word holding buffer, runtime length and bit order.
// Define TX_SER_PARITY_EN to add the par_type port and a trailing parity bit per word.
module tx_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ser_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  msb_first,
`ifdef TX_SER_PARITY_EN
  input  logic                  par_type,
`endif
  output logic                  ser_data,
  output logic                  ser_active,
  output logic                  ser_done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
`ifdef TX_SER_PARITY_EN
    PARITY,
`endif
    IDLE,
    SHIFT
  } state_t;

  state_t state_r, state_nxt;

  logic                  buf_full;
  logic                  buf_full_nxt;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [LEN_W-1:0]      buf_len;
  logic                  buf_msb;

  logic [DATA_WIDTH-1:0] sreg;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      len_r;
  logic [LEN_W-1:0]      len_m1;
  logic                  msb_r;
  logic                  msb_tap;

  logic accept;
  logic load;
  logic adv;
  logic finish;

`ifdef TX_SER_PARITY_EN
  logic buf_par;
  logic par_r;
`endif

  // Zero and oversize lengths both mean a full-width word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

`ifdef TX_SER_PARITY_EN
  function automatic logic word_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [LEN_W-1:0]      l,
                                       input logic                  odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (LEN_W'(i) < l) p = p ^ d[i];
    return p;
  endfunction
`endif

  assign accept       = in_valid & in_ready;
  assign buf_full_nxt = accept ? 1'b1 : (load ? 1'b0 : buf_full);
  assign len_m1       = len_r - LEN_W'(1);

  // MSB-first output tap sits at the top of the active length, not the register.
  always_comb begin
    msb_tap = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (LEN_W'(i) == len_m1) msb_tap = sreg[i];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= IDLE;
    else      state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    load      = 1'b0;
    adv       = 1'b0;
    finish    = 1'b0;
    case (state_r)
      IDLE: begin
        if (buf_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          adv = 1'b1;
          if (cnt == len_m1) begin
`ifdef TX_SER_PARITY_EN
            state_nxt = PARITY;
`else
            finish = 1'b1;
`endif
          end
        end
      end
`ifdef TX_SER_PARITY_EN
      PARITY: begin
        if (ser_en) finish = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // A waiting word is chained on the completing edge so frames abut.
    if (finish) begin
      if (buf_full) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    ser_data = 1'b1;
    case (state_r)
      SHIFT:   ser_data = msb_r ? msb_tap : sreg[0];
`ifdef TX_SER_PARITY_EN
      PARITY:  ser_data = par_r;
`endif
      default: ser_data = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_full   <= 1'b0;
      in_ready   <= 1'b1;
      buf_data   <= '0;
      buf_len    <= MAX_LEN;
      buf_msb    <= 1'b0;
      sreg       <= '0;
      cnt        <= '0;
      len_r      <= MAX_LEN;
      msb_r      <= 1'b0;
      ser_active <= 1'b0;
      ser_done   <= 1'b0;
`ifdef TX_SER_PARITY_EN
      buf_par    <= 1'b0;
      par_r      <= 1'b0;
`endif
    end else begin
      buf_full   <= buf_full_nxt;
      in_ready   <= ~buf_full_nxt;
      ser_active <= (state_nxt != IDLE);
      ser_done   <= finish;
      if (accept) begin
        buf_data <= in_data;
        buf_len  <= clamp_len(data_len);
        buf_msb  <= msb_first;
`ifdef TX_SER_PARITY_EN
        buf_par  <= word_parity(in_data, clamp_len(data_len), par_type);
`endif
      end
      if (load) begin
        sreg  <= buf_data;
        cnt   <= '0;
        len_r <= buf_len;
        msb_r <= buf_msb;
`ifdef TX_SER_PARITY_EN
        par_r <= buf_par;
`endif
      end else if (adv) begin
        sreg <= msb_r ? (sreg << 1) : (sreg >> 1);
        cnt  <= cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Self-checking bench for tx_frame_serializer: serial stream compared against a
// word-level reference model of expected bits and done-pulse timing.
`timescale 1ns/1ps
module tb_tx_frame_serializer;
  localparam int W  = 8;
  localparam int LW = $clog2(W + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ser_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          msb_first = 1'b0;
  logic          par_type = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [LW-1:0] data_len = '0;
  logic          in_ready, ser_data, ser_active, ser_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_mode = 1;
  int idle_bad = 0;
  int active_lows = 0;

  bit obs_bits[$];
  int bit_cyc[$];
  int done_cyc[$];
  bit exp_bits[$];
  int exp_nbits[$];

  tx_frame_serializer #(.DATA_WIDTH(W), .LEN_W(LW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ser_en    (ser_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .data_len  (data_len),
    .msb_first (msb_first),
`ifdef TX_SER_PARITY_EN
    .par_type  (par_type),
`endif
    .ser_data  (ser_data),
    .ser_active(ser_active),
    .ser_done  (ser_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ser_en pattern: 1 = every cycle, N>1 = every Nth cycle, 0 = random
  initial forever begin
    @(posedge CLK);
    #1;
    if (en_mode == 1)      ser_en = 1'b1;
    else if (en_mode == 0) ser_en = ($urandom_range(0, 2) == 0);
    else                   ser_en = ((cyc % en_mode) == 0);
  end

  // Recorder: a bit is transmitted when it is on the line while ser_en is high.
  always @(negedge CLK) begin
    if (RST) begin
      if (ser_active && ser_en) begin
        obs_bits.push_back(ser_data);
        bit_cyc.push_back(cyc);
      end
      if (ser_done) done_cyc.push_back(cyc);
      if (!ser_active && ser_data !== 1'b1) idle_bad++;
      if (!ser_active) active_lows++;
    end
  end

  task automatic model_word(input logic [W-1:0] d, input logic [LW-1:0] dl,
                            input logic m, input logic pt);
    int L;
    L = (dl == 0 || int'(dl) > W) ? W : int'(dl);
    for (int i = 0; i < L; i++) exp_bits.push_back(m ? d[L-1-i] : d[i]);
`ifdef TX_SER_PARITY_EN
    begin
      bit p;
      p = pt;
      for (int i = 0; i < L; i++) p = p ^ d[i];
      exp_bits.push_back(p);
      L++;
    end
`endif
    exp_nbits.push_back(L);
  endtask

  task automatic clear_all();
    obs_bits.delete();
    bit_cyc.delete();
    done_cyc.delete();
    exp_bits.delete();
    exp_nbits.delete();
    idle_bad = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] dl,
                      input logic m, input logic pt);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready got %b want 1", in_ready);
    end else begin
      in_data = d; data_len = dl; msb_first = m; par_type = pt; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      model_word(d, dl, m, pt);
    end
  endtask

  task automatic wait_done(input int n);
    int guard;
    guard = 0;
    while (done_cyc.size() < n && guard < 5000) begin
      tick(1);
      guard++;
    end
    checks++;
    if (done_cyc.size() < n) begin
      errors++;
      $display("FAIL wait_done got %0d pulses want %0d", done_cyc.size(), n);
    end
  endtask

  task automatic wait_active();
    int guard;
    guard = 0;
    while (ser_active !== 1'b1 && guard < 100) begin
      tick(1);
      guard++;
    end
    checks++;
    if (ser_active !== 1'b1) begin
      errors++;
      $display("FAIL wait_active got %b want 1", ser_active);
    end
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge CLK);
    checks++;
    if ({ser_data, in_ready, ser_active, ser_done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs got %b want 1100", {ser_data, in_ready, ser_active, ser_done});
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    en_mode = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({ser_data, in_ready, ser_active, ser_done} !== 4'b1100) begin
        errors++;
        $display("FAIL idle_outputs cyc %0d got %b want 1100", i, {ser_data, in_ready, ser_active, ser_done});
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (obs_bits.size() != 0 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL idle_activity got bits %0d dones %0d want 0 0", obs_bits.size(), done_cyc.size());
    end
  endtask

  task automatic test_lsb_a5();
    logic [7:0] expv;
    expv = 8'hA5;
    clear_all();
    en_mode = 1;
    send(8'hA5, 4'd8, 1'b0, 1'b0);
    wait_done(1);
    tick(10);
    checks++;
    if (obs_bits.size() != exp_nbits[0]) begin
      errors++;
      $display("FAIL a5_len got %0d want %0d", obs_bits.size(), exp_nbits[0]);
    end else begin
      for (int i = 0; i < obs_bits.size(); i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i] || (i < 8 && obs_bits[i] !== expv[i])) begin
          errors++;
          $display("FAIL a5_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
        end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != bit_cyc[obs_bits.size()-1] + 1) begin
        errors++;
        $display("FAIL a5_done got %0d pulses at %0d want 1 at %0d", done_cyc.size(),
                 done_cyc[0], bit_cyc[obs_bits.size()-1] + 1);
      end
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL a5_idle_line got %0d want 0", idle_bad);
    end
  endtask

  task automatic test_msb_0d();
    logic [4:0] expv;
    expv = 5'b10110;
    clear_all();
    en_mode = 1;
    send(8'h0D, 4'd5, 1'b1, 1'b0);
    wait_done(1);
    tick(10);
    checks++;
    if (obs_bits.size() != exp_nbits[0]) begin
      errors++;
      $display("FAIL 0d_len got %0d want %0d", obs_bits.size(), exp_nbits[0]);
    end else begin
      for (int i = 0; i < obs_bits.size(); i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i] || (i < 5 && obs_bits[i] !== expv[i]) ||
            (i == 5 && obs_bits[i] !== 1'b1)) begin
          errors++;
          $display("FAIL 0d_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++;
      $display("FAIL 0d_done got %0d want 1", done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int lows0;
    int nb0;
    clear_all();
    en_mode = 4;
    send(8'h01, 4'd8, 1'b0, 1'b0);
    wait_active();
    lows0 = active_lows;
    send(8'hFF, 4'd8, 1'b0, 1'b1);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_buffered_ready got %b want 0", in_ready);
    end
    @(posedge CLK); #1;
    wait_done(1);
    checks++;
    if (active_lows != lows0) begin
      errors++;
      $display("FAIL b2b_active_gap got %0d low cycles want 0", active_lows - lows0);
    end
    wait_done(2);
    tick(10);
    nb0 = exp_nbits[0];
    checks++;
    if (done_cyc.size() != 2 || obs_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL b2b_counts got dones %0d bits %0d want 2 %0d", done_cyc.size(),
               obs_bits.size(), exp_bits.size());
    end else begin
      checks++;
      if (done_cyc[1] - done_cyc[0] != exp_nbits[1] * 4) begin
        errors++;
        $display("FAIL b2b_done_spacing got %0d want %0d", done_cyc[1] - done_cyc[0], exp_nbits[1] * 4);
      end
      checks++;
      if (bit_cyc[nb0] - bit_cyc[nb0-1] != 4) begin
        errors++;
        $display("FAIL b2b_word_gap got %0d want 4", bit_cyc[nb0] - bit_cyc[nb0-1]);
      end
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL b2b_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [W-1:0] d;
    d = W'($urandom);
    clear_all();
    en_mode = 1;
    send(d, 4'd0, 1'b1, 1'b0);
    send(d, 4'd12, 1'b1, 1'b0);
    send(d, 4'd8, 1'b1, 1'b0);
    wait_done(3);
    tick(10);
    checks++;
    if (obs_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL clamp_len got %0d want %0d", obs_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL clamp_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int nw;
    int endi;
    nw = 16;
    clear_all();
    en_mode = 0;
    for (int k = 0; k < nw; k++) begin
      send(W'($urandom), LW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 30));
    end
    wait_done(nw);
    tick(40);
    checks++;
    if (obs_bits.size() != exp_bits.size() || done_cyc.size() != nw) begin
      errors++;
      $display("FAIL rand_counts got bits %0d dones %0d want %0d %0d", obs_bits.size(),
               done_cyc.size(), exp_bits.size(), nw);
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i]) begin
          errors++;
          $display("FAIL rand_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
        end
      end
      endi = -1;
      for (int k = 0; k < nw; k++) begin
        endi += exp_nbits[k];
        checks++;
        if (done_cyc[k] != bit_cyc[endi] + 1) begin
          errors++;
          $display("FAIL rand_done%0d got cyc %0d want %0d", k, done_cyc[k], bit_cyc[endi] + 1);
        end
      end
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL rand_idle_line got %0d want 0", idle_bad);
    end
  endtask

  task automatic test_reset_midframe();
    int guard;
    clear_all();
    en_mode = 2;
    send(8'h5A, 4'd8, 1'b0, 1'b0);
    wait_active();
    send(8'hC3, 4'd8, 1'b1, 1'b1);
    guard = 0;
    while (obs_bits.size() < 3 && guard < 200) begin
      tick(1);
      guard++;
    end
    checks++;
    if (obs_bits.size() != 3) begin
      errors++;
      $display("FAIL rstmid_prebits got %0d want 3", obs_bits.size());
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({ser_data, in_ready, ser_active, ser_done} !== 4'b1100) begin
      errors++;
      $display("FAIL rstmid_outputs got %b want 1100", {ser_data, in_ready, ser_active, ser_done});
    end
    tick(2);
    RST = 1'b1;
    tick(40);
    checks++;
    if (obs_bits.size() != 3 || done_cyc.size() != 0 || idle_bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got bits %0d dones %0d idle_bad %0d ready %b want 3 0 0 1",
               obs_bits.size(), done_cyc.size(), idle_bad, in_ready);
    end
    for (int i = 0; i < 3 && i < obs_bits.size(); i++) begin
      checks++;
      if (obs_bits[i] !== exp_bits[i]) begin
        errors++;
        $display("FAIL rstmid_bit%0d got %b want %b", i, obs_bits[i], exp_bits[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_a5();
    test_msb_0d();
    test_back_to_back();
    test_len_clamp();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
